mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle main controller for the RV32I core. It decodes `op` into a Moore state machine and drives the datapath enables and mux selects cycle by cycle: instruction fetch, register fetch, address generation, memory access, execute and write-back. It hands `ALUOp` to the ALU decoder and `ImmSrc` to the immediate extender. Instruction and data memory share one port, gated by a `mem_ready` handshake with a watchdog.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum number of cycles a memory state waits for `mem_ready`. A value of 0 disables the watchdog.
- `clk` input 1: clock. One clock domain; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `op` input 7: instr[6:0].
- `Zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `mem_req` output 1: memory access request.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `AdrSrc` output 1 each: datapath enables and address-mux select.
- `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ALUOp`, `ImmSrc` output 2 each: mux selects and decode controls.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `bus_err` output 1: one-cycle pulse on a watchdog expiry.

## Operation
Unlisted outputs are 0.

- **FETCH**
  - Drives `mem_req`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - While `mem_ready`=0: holds state.
  - When `mem_ready`=1: drives `IRWrite`=1 and PC update, then goes to DECODE.
- **DECODE**
  - Drives `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00.
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other opcode → FETCH with `illegal`=1.
- **MEMADR**
  - Drives `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - Goes to MEMRD if `op`[5]=0, otherwise MEMWR.
- **MEMRD**
  - Drives `mem_req`=1, `AdrSrc`=1, `ResultSrc`=00.
  - Holds until `mem_ready`=1, then goes to MEMWB.
- **MEMWB**
  - Drives `ResultSrc`=01, `RegWrite`=1.
  - Goes to FETCH.
- **MEMWR**
  - Drives `mem_req`=1, `AdrSrc`=1, `ResultSrc`=00.
  - `MemWrite`=1 only in the cycle where `mem_ready`=1; FETCH follows that cycle.
- **EXECR**
  - Drives `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - Goes to ALUWB.
- **EXECI**
  - Same as EXECR except `ALUSrcB`=01.
  - Goes to ALUWB.
- **ALUWB**
  - Drives `ResultSrc`=00, `RegWrite`=1.
  - Goes to FETCH.
- **JAL**
  - Drives `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, PC update.
  - Goes to ALUWB.
- **BEQ**
  - Drives `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, branch.
  - Goes to FETCH.
- **PCWrite** = PC update | (branch & `Zero`).
- **ImmSrc** is decoded combinationally from `op` in every state:
  - 0000011, 0010011, 1100111 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other value → 00.
- **Watchdog**
  - Counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle spent there with `mem_ready`=0.
  - When the count reaches `MEM_WAIT_MAX` with `mem_ready` still 0:
    - `bus_err` pulses for one cycle;
    - the state goes to FETCH;
    - no `IRWrite`, `RegWrite` or `MemWrite` is issued for the abandoned access.
  - The counter saturates and never wraps.

## Timing
- **Reset:** `reset`=0 at a clock edge places the state in FETCH and clears the watchdog counter. This applies mid-instruction and mid-wait.
- **During reset:** all enables, `mem_req`, `illegal` and `bus_err` are forced to 0.
- **After release:** the first cycle is FETCH.
- **Output type:** outputs are combinational from state, `op`, `mem_ready` and `Zero`. There are no output registers and zero added latency.
- **Cycle counts with `mem_ready` tied to 1:**
  - lw: 5 cycles
  - sw, R-type, I-type ALU, jal: 4 cycles
  - beq: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- If `mem_ready`=1 in the same cycle the counter hits its limit, the access completes and `bus_err` stays 0.
- `op` is sampled only in DECODE and MEMADR; it is stable after `IRWrite`.

## Configuration
- **`MC_CTRL_JALR_EN` defined:**
  - `op`=1100111 in DECODE → JALR.
  - JALR drives `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00, `ResultSrc`=10, PC update, then goes to JLINK.
  - JLINK drives `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, then goes to ALUWB.
  - jalr takes 5 cycles.
- **Not defined:** 1100111 is illegal (`illegal` pulse, return to FETCH). JALR and JLINK states are absent.

## Test plan
- Reset low for 3 cycles during MEMRD, then release → all enables 0 while low; FETCH with `mem_req`=1 on the first released cycle.
- add (`op`=0110011), `mem_ready`=1 → FETCH, DECODE, EXECR (`ALUOp`=10), ALUWB (`RegWrite`=1); 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total; `RegWrite`=1 only in MEMWB.
- beq with `Zero`=1, then `Zero`=0 → `PCWrite`=1 in BEQ for the first; `PCWrite`=0 in BEQ for the second.
- `mem_ready` held 0 in MEMWR with `MEM_WAIT_MAX`=15 → `bus_err` pulses once on the 15th wait cycle; `MemWrite` never asserts; next state FETCH.
- `op`=1100111 → with `MC_CTRL_JALR_EN`: JALR, JLINK, ALUWB, 5 cycles. Without it: `illegal`=1 in DECODE.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RV32I main controller (Moore FSM + shared-memory handshake), optional jalr via MC_CTRL_JALR_EN.
// Latency: outputs are combinational from state/op/mem_ready/Zero, no added cycles.
// Backpressure: memory states hold on mem_ready=0; watchdog aborts to FETCH with a bus_err pulse.
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       bus_err
);

  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, BEQ
`ifdef MC_CTRL_JALR_EN
    , JALR, JLINK
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wcnt;
  logic          waiting, timeout, pc_upd, branch;

  always_comb begin
    waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    timeout = waiting && !mem_ready && (MEM_WAIT_MAX != 0) && (int'(wcnt) == MEM_WAIT_MAX - 1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      // Any cycle that is not a continued wait (completion, abort, other state) restarts the count.
      if (waiting && !mem_ready && !timeout) begin
        if (int'(wcnt) != MEM_WAIT_MAX) wcnt <= wcnt + CW'(1);
      end else begin
        wcnt <= '0;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    illegal   = 1'b0;
    pc_upd    = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          pc_upd  = 1'b1;
          state_n = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_n = MEMADR;
          7'b0110011:             state_n = EXECR;
          7'b0010011:             state_n = EXECI;
          7'b1101111:             state_n = JAL;
          7'b1100011:             state_n = BEQ;
`ifdef MC_CTRL_JALR_EN
          7'b1100111:             state_n = JALR;
`endif
          default: begin
            illegal = 1'b1;
            state_n = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_n = op[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_n   = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          MemWrite = 1'b1;
          state_n  = FETCH;
        end
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_n  = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
        state_n = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        state_n = FETCH;
      end
`ifdef MC_CTRL_JALR_EN
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_upd    = 1'b1;
        state_n   = JLINK;
      end
      JLINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_n = ALUWB;
      end
`endif
      default: state_n = FETCH;
    endcase
    if (timeout) state_n = FETCH;
    PCWrite = pc_upd | (branch & Zero);
    bus_err = timeout;
    if (!reset) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction control-word sequences from an instruction-level model, randomized handshake.
module tb_mc_ctrl;

  localparam int WMAX = 15;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111, BR = 7'b1100011, JR = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal, bus_err;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
  logic [17:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] exp_q[$];
  logic        mr_q[$];
  logic        z_q[$];
  logic [6:0]  op_q[$];

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .bus_err(bus_err)
  );

  assign ctl = {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, illegal, bus_err};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      SW:      return 2'b01;
      BR:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [17:0] mk(input logic [6:0] o, input logic mreq, pcw, irw, rw, mw, adr,
                                     input logic [1:0] a, b, rs, aop, input logic ill);
    return {mreq, pcw, irw, rw, mw, adr, a, b, rs, aop, imm_of(o), ill, 1'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic z, input logic [6:0] o, input logic [17:0] w);
    mr_q.push_back(mr);
    z_q.push_back(z);
    op_q.push_back(o);
    exp_q.push_back(w);
  endtask

  // A memory phase: 'waits' not-ready cycles then completion, unless the watchdog gives up first.
  task automatic mem_phase(input logic [6:0] o, input int waits, input logic [17:0] base,
                           input logic [17:0] done, output logic aborted);
    aborted = 1'b0;
    for (int i = 0; i < waits; i++) begin
      if (WMAX != 0 && i + 1 == WMAX) begin
        push(1'b0, rb(), o, base | 18'h1);
        aborted = 1'b1;
        return;
      end
      push(1'b0, rb(), o, base);
    end
    push(1'b1, rb(), o, done);
  endtask

  function automatic logic is_legal(input logic [6:0] o);
`ifdef MC_CTRL_JALR_EN
    return o inside {LW, SW, RT, IT, JL, BR, JR};
`else
    return o inside {LW, SW, RT, IT, JL, BR};
`endif
  endfunction

  // Whole-instruction expected control sequence.
  task automatic build(input logic [6:0] o, input logic zero, input int fw, input int mw);
    logic ab;
    logic [17:0] wb;
    wb = mk(o, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    mem_phase(o, fw, mk(o, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0),
              mk(o, 1, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), ab);
    if (ab) return;
    push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, !is_legal(o)));
    if (!is_legal(o)) return;
    case (o)
      LW: begin
        push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        mem_phase(o, mw, mk(o, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                  mk(o, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), ab);
        if (!ab) push(rb(), rb(), o, mk(o, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0));
      end
      SW: begin
        push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
        mem_phase(o, mw, mk(o, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0),
                  mk(o, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), ab);
      end
      RT: begin
        push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0));
        push(rb(), rb(), o, wb);
      end
      IT: begin
        push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0));
        push(rb(), rb(), o, wb);
      end
      JL: begin
        push(rb(), rb(), o, mk(o, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        push(rb(), rb(), o, wb);
      end
      BR: push(rb(), zero, o, mk(o, 0, zero, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0));
      default: begin
        push(rb(), rb(), o, mk(o, 0, 1, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0));
        push(rb(), rb(), o, mk(o, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0));
        push(rb(), rb(), o, wb);
      end
    endcase
  endtask

  task automatic test_reset();
    logic [17:0] want;
    int step = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = rb(); Zero = rb(); #1;
      vectors++;
      if ({ctl[17:13], ctl[1:0]} !== 7'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: enables=%b expected 0000000", i, {ctl[17:13], ctl[1:0]});
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; op = RT; #1;
    vectors++;
    want = mk(RT, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    if (ctl !== want) begin
      miscompares++;
      $display("FAIL reset_release: ctl=%b expected %b", ctl, want);
    end
    build(RT, 0, 1, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL reset_first_instr step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_alu();
    logic [17:0] want;
    int step = 0;
    build(RT, 0, 0, 0);
    build(IT, 1, 0, 0);
    build(RT, 1, 2, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL alu step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_load_store();
    logic [17:0] want;
    int step = 0;
    build(LW, 0, 0, 2);
    build(LW, 0, 0, 0);
    build(SW, 0, 0, 0);
    build(SW, 0, 1, 3);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL load_store step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [17:0] want;
    int step = 0;
    build(BR, 1, 0, 0);
    build(BR, 0, 0, 0);
    build(JL, 0, 0, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL branch_jump step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_illegal_jalr();
    logic [17:0] want;
    int step = 0;
    build(JR, 0, 0, 0);
    build(7'b0000000, 0, 0, 0);
    build(7'b0110111, 0, 0, 0);
    build(IT, 0, 0, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL illegal_jalr step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [17:0] want;
    int step = 0;
    build(SW, 0, 0, 15);
    build(LW, 0, 0, 14);
    build(RT, 0, 15, 0);
    build(RT, 0, 14, 0);
    build(LW, 0, 0, 20);
    build(IT, 0, 0, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL watchdog step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_reset_midinstr();
    logic [17:0] want;
    int step = 0;
    push(1'b1, rb(), LW, mk(LW, 1, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0));
    push(rb(), rb(), LW, mk(LW, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0));
    push(rb(), rb(), LW, mk(LW, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0));
    for (int i = 0; i < 4; i++) push(1'b0, rb(), LW, mk(LW, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL midreset_lead step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b0; mem_ready = rb(); #1;
      vectors++;
      if ({ctl[17:13], ctl[1:0]} !== 7'b0) begin
        miscompares++;
        $display("FAIL midreset_hold cycle %0d: enables=%b expected 0000000", i, {ctl[17:13], ctl[1:0]});
      end
    end
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; op = RT; #1;
    vectors++;
    want = mk(RT, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    if (ctl !== want) begin
      miscompares++;
      $display("FAIL midreset_release: ctl=%b expected %b", ctl, want);
    end
    // 1 + 13 fetch waits stays under the limit only if reset cleared the counter.
    build(RT, 0, 13, 0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL midreset_after step %0d: ctl=%b expected %b", step, ctl, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] want;
    logic [6:0] ops [10];
    int step = 0;
    ops = '{LW, SW, RT, IT, JL, BR, JR, 7'b0000000, 7'b1111111, 7'b0010111};
    for (int n = 0; n < 60; n++) begin
      int fw, mw;
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      build(ops[$urandom_range(0, 9)], rb(), fw, mw);
    end
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front(); Zero = z_q.pop_front(); op = op_q.pop_front(); want = exp_q.pop_front();
      #1; vectors++; step++;
      if (ctl !== want) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: op=%b ctl=%b expected %b", step, op, ctl, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_illegal_jalr();
    test_watchdog();
    test_reset_midinstr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
